// File: rtl/bit_serial_alu.sv
// Bit-serial AND/OR/ADD/SUB ALU, LSB first: done pulses WIDTH+1 cycles after the accepted start.
// Backpressure: start is honoured only while ready (IDLE); requests during RUN/DONE are dropped.
module bit_serial_alu #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [1:0]       op,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_ADD = 2'b10;
   localparam logic [1:0] OP_SUB = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sh_q, a_sh_d;
   logic [WIDTH-1:0] b_sh_q, b_sh_d;
   // The final result bit goes straight to out, so only WIDTH-1 bits are accumulated.
   logic [WIDTH-2:0] res_sh_q, res_sh_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             carry_out_q, carry_out_d;
   logic             overflow_q, overflow_d;
   logic             zero_q, zero_d;

   logic             bit_a;
   logic             bit_b;
   logic             is_arith;
   logic             slice_r;
   logic             slice_c;
   logic [WIDTH-1:0] res_next;

   // One-bit ALU slice fed from the operand shift registers.
   always_comb begin
      bit_a    = a_sh_q[0];
      bit_b    = (op_q == OP_SUB) ? ~b_sh_q[0] : b_sh_q[0];
      is_arith = op_q[1];
      slice_r  = bit_a ^ bit_b ^ carry_q;
      slice_c  = carry_q;
      case (op_q)
         OP_AND:  slice_r = bit_a & bit_b;
         OP_OR:   slice_r = bit_a | bit_b;
         default: slice_c = (bit_a & bit_b) | (bit_a & carry_q) | (bit_b & carry_q);
      endcase
      res_next = {slice_r, res_sh_q};
   end

   always_comb begin
      state_d     = state_q;
      a_sh_d      = a_sh_q;
      b_sh_d      = b_sh_q;
      res_sh_d    = res_sh_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      op_d        = op_q;
      out_d       = out_q;
      carry_out_d = carry_out_q;
      overflow_d  = overflow_q;
      zero_d      = zero_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_sh_d   = A;
               b_sh_d   = B;
               op_d     = op;
               carry_d  = (op == OP_SUB);
               res_sh_d = '0;
               cnt_d    = '0;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
            res_sh_d = res_next[WIDTH-1:1];
            carry_d  = slice_c;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
               // Carry into the MSB differs from carry out of it exactly on signed overflow.
               cnt_d       = '0;
               out_d       = res_next;
               zero_d      = ~|res_next;
               carry_out_d = is_arith & slice_c;
               overflow_d  = is_arith & (carry_q ^ slice_c);
               state_d     = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         a_sh_q      <= '0;
         b_sh_q      <= '0;
         res_sh_q    <= '0;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         op_q        <= OP_AND;
         out_q       <= '0;
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
         zero_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         a_sh_q      <= a_sh_d;
         b_sh_q      <= b_sh_d;
         res_sh_q    <= res_sh_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         op_q        <= op_d;
         out_q       <= out_d;
         carry_out_q <= carry_out_d;
         overflow_q  <= overflow_d;
         zero_q      <= zero_d;
      end
   end

   assign ready     = (state_q == ST_IDLE);
   assign busy      = (state_q == ST_RUN);
   assign done      = (state_q == ST_DONE);
   assign out       = out_q;
   assign carry_out = carry_out_q;
   assign overflow  = overflow_q;
   assign zero      = zero_q;

endmodule
